pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter STAGES, 5, number of pipeline stages (index 0 = IF, youngest; STAGES-1 = WB, oldest); legal range 3..8.
REQ-002 Parameter CNT_W, 4, width of the timed-stall cycle count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 requireStall  input  STAGES  per-stage level stall request.
REQ-006 requireFlush  input  STAGES  per-stage redirect request; kills all younger stages.
REQ-007 timedStallValid  input  1  load strobe for a multi-cycle stall.
REQ-008 timedStallStage  input  clog2(STAGES)  stage targeted by the load.
REQ-009 timedStallCycles  input  CNT_W  stall length in cycles; 0 ignored.
REQ-010 pcStall  output  1  hold PC.
REQ-011 regStall  output  STAGES-1  hold boundary register b (between stage b and b+1).
REQ-012 regFlush  output  STAGES-1  bubble boundary register b.
REQ-013 pcRedirect  output  1  a flush is taken this cycle.
REQ-014 flushSource  output  clog2(STAGES)  stage whose flush is taken; 0 when pcRedirect=0.
REQ-015 stallCycleCount  output  32  saturating count of cycles with pcStall=1.
REQ-016 flushCount  output  16  saturating count of cycles with pcRedirect=1.

Function
REQ-017 effStall[i] SHALL be requireStall[i] OR cnt[i]!=0 OR (timedStallValid AND timedStallStage==i AND timedStallCycles!=0).
REQ-018 K SHALL be the highest i with effStall[i]; J the highest i with requireFlush[i] and i>K (any i if no effStall).
REQ-019 If J exists: pcRedirect=1, flushSource=J, pcStall=0, regStall=0, regFlush[b]=1 for b<J, else 0.
REQ-020 Else if K exists: pcStall=1, regStall[b]=1 for b<K, regFlush[K]=1 if K<=STAGES-2, all other bits 0.
REQ-021 Else all of pcStall, regStall, regFlush, pcRedirect SHALL be 0.
REQ-022 Flush requests at stages <=K SHALL be ignored that cycle (requester is frozen and re-asserts).
REQ-023 Outputs REQ-019..021 SHALL be combinational (zero latency) from inputs and counter state.
REQ-024 Load of N>0 into stage s SHALL stall s for exactly N cycles starting with the load cycle: cnt[s] <= N-1.
REQ-025 Load while cnt[s]!=0 SHALL set cnt[s] <= max(cnt[s]-1, N-1); the longer stall wins.
REQ-026 Each nonzero cnt[i] SHALL decrement by 1 per cycle, independent of other stages' stalls.
REQ-027 When a flush from J is taken, cnt[i] for i<J SHALL clear to 0 and a same-cycle load to s<J SHALL be discarded.
REQ-028 timedStallStage >= STAGES SHALL be ignored.
REQ-029 stallCycleCount and flushCount SHALL increment per qualifying cycle and hold at all-ones.

Reset
REQ-030 While rst=1, all cnt[i], stallCycleCount, flushCount SHALL load 0 on the clock edge.
REQ-031 While rst=1, pcStall, regStall, regFlush, pcRedirect, flushSource SHALL be forced to 0 regardless of inputs.
REQ-032 Reset mid timed-stall SHALL abandon the stall; first cycle after rst deassert shows no stall unless re-requested.

Structure
REQ-033 Package pipeline_ctrl_pkg SHALL hold STAGES/CNT_W defaults and stage index constants IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-034 Per-stage counter SHALL be sub-module stall_timer (load, max-merge, decrement, clear), instanced STAGES times.
REQ-035 Priority encoding for K and J SHALL be parametrised loops, no per-stage hand-coding.

Verification (STAGES=5)
REQ-036 Single level stall each stage 0..4 -> K=2: pcStall=1, regStall=0011, regFlush=0100; K=4: regStall=1111, regFlush=0000.
REQ-037 Load EX (2) N=3 with no other requests -> pcStall=1 for exactly 3 cycles, then 0; stallCycleCount +3.
REQ-038 Timed stall EX N=5, after 1 cycle requireFlush[3] -> pcRedirect=1, flushSource=3, regFlush=0111, cnt[2]=0, next cycle no stall.
REQ-039 requireStall[3] and requireFlush[2] together -> stall wins (regStall=0111, regFlush=1000, pcRedirect=0); drop stall -> flush taken.
REQ-040 Reload EX N=2 while cnt=4 -> remaining unchanged (longer wins); reload N=8 while cnt=1 -> stall lasts 8 cycles from reload.
REQ-041 Assert rst during a timed stall with requireStall[1]=1 -> all outputs 0 during rst; counters 0; after release only requireStall stall visible.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | pipeline_ctrl_pkg: shared defaults, stage indices, hazard actions    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pipeline_ctrl_pkg;

  localparam int STAGES_DEFAULT = 5;
  localparam int CNT_W_DEFAULT  = 4;

  localparam int IF  = 0;
  localparam int ID  = 1;
  localparam int EX  = 2;
  localparam int MEM = 3;
  localparam int WB  = 4;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } hazard_act_e;

endpackage

`default_nettype wire

// File: rtl/stall_timer.sv
// +----------------------------------------------------------------------+
// | stall_timer: per-stage remaining-stall counter (load/max/dec/clear)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module stall_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cycles,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_dec;
  logic [CNT_W-1:0] load_m1;

  // The load cycle itself counts as the first stalled cycle, hence N-1.
  assign cnt_dec = (cnt != '0) ? cnt - CNT_W'(1) : '0;
  assign load_m1 = load_cycles - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load && (load_m1 > cnt_dec)) begin
      cnt <= load_m1;
    end else begin
      cnt <= cnt_dec;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush arbitration for an in-order pipe   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT,
  localparam int SW    = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] requireStall,
  input  logic [STAGES-1:0] requireFlush,
  input  logic              timedStallValid,
  input  logic [SW-1:0]     timedStallStage,
  input  logic [CNT_W-1:0]  timedStallCycles,
  output logic              pcStall,
  output logic [STAGES-2:0] regStall,
  output logic [STAGES-2:0] regFlush,
  output logic              pcRedirect,
  output logic [SW-1:0]     flushSource,
  output logic [31:0]       stallCycleCount,
  output logic [15:0]       flushCount
);

  logic [STAGES-1:0] load_hit;
  logic [STAGES-1:0] eff_stall;
  logic [STAGES-1:0] timer_clear;
  logic [CNT_W-1:0]  timer_cnt [STAGES];

  logic        k_found;
  logic        j_found;
  int          k_idx;
  int          j_idx;
  hazard_act_e act;

  // Out-of-range stage numbers never match any i, so they are ignored here.
  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      assign load_hit[i]  = timedStallValid && (timedStallStage == SW'(i)) &&
                            (timedStallCycles != '0);
      assign eff_stall[i] = requireStall[i] || (timer_cnt[i] != '0) || load_hit[i];

      stall_timer #(
        .CNT_W (CNT_W)
      ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (load_hit[i]),
        .load_cycles (timedStallCycles),
        .clear       (timer_clear[i]),
        .cnt         (timer_cnt[i])
      );
    end
  endgenerate

  // Oldest stalled stage K blocks flushes from itself and younger stages.
  always_comb begin
    k_found = 1'b0;
    k_idx   = 0;
    j_found = 1'b0;
    j_idx   = 0;
    for (int i = 0; i < STAGES; i++) begin
      if (eff_stall[i]) begin
        k_found = 1'b1;
        k_idx   = i;
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      if (requireFlush[i] && (!k_found || (i > k_idx))) begin
        j_found = 1'b1;
        j_idx   = i;
      end
    end
    if (rst) begin
      act = ACT_NONE;
    end else if (j_found) begin
      act = ACT_FLUSH;
    end else if (k_found) begin
      act = ACT_STALL;
    end else begin
      act = ACT_NONE;
    end
  end

  always_comb begin
    pcStall     = 1'b0;
    regStall    = '0;
    regFlush    = '0;
    pcRedirect  = 1'b0;
    flushSource = '0;
    timer_clear = '0;
    case (act)
      ACT_FLUSH: begin
        pcRedirect  = 1'b1;
        flushSource = SW'(j_idx);
        for (int b = 0; b < STAGES - 1; b++) begin
          regFlush[b] = (b < j_idx);
        end
        for (int i = 0; i < STAGES; i++) begin
          timer_clear[i] = (i < j_idx);
        end
      end
      ACT_STALL: begin
        pcStall = 1'b1;
        for (int b = 0; b < STAGES - 1; b++) begin
          regStall[b] = (b < k_idx);
          regFlush[b] = (b == k_idx);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCycleCount <= '0;
      flushCount      <= '0;
    end else begin
      if (pcStall && (stallCycleCount != '1)) begin
        stallCycleCount <= stallCycleCount + 32'd1;
      end
      if (pcRedirect && (flushCount != '1)) begin
        flushCount <= flushCount + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed self-checking bench, STAGES=5      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  requireStall;
  logic [4:0]  requireFlush;
  logic        timedStallValid;
  logic [2:0]  timedStallStage;
  logic [3:0]  timedStallCycles;
  logic        pcStall;
  logic [3:0]  regStall;
  logic [3:0]  regFlush;
  logic        pcRedirect;
  logic [2:0]  flushSource;
  logic [31:0] stallCycleCount;
  logic [15:0] flushCount;

  int n_checks;
  int n_errors;
  int sc;
  int fc;

  pipeline_hazard_ctrl #(
    .STAGES (5),
    .CNT_W  (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .requireStall     (requireStall),
    .requireFlush     (requireFlush),
    .timedStallValid  (timedStallValid),
    .timedStallStage  (timedStallStage),
    .timedStallCycles (timedStallCycles),
    .pcStall          (pcStall),
    .regStall         (regStall),
    .regFlush         (regFlush),
    .pcRedirect       (pcRedirect),
    .flushSource      (flushSource),
    .stallCycleCount  (stallCycleCount),
    .flushCount       (flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are checked just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic ps, input logic [3:0] rs,
                            input logic [3:0] rf, input logic pr, input logic [2:0] fs);
    check({tag, ".pcStall"},     32'(pcStall),     32'(ps));
    check({tag, ".regStall"},    32'(regStall),    32'(rs));
    check({tag, ".regFlush"},    32'(regFlush),    32'(rf));
    check({tag, ".pcRedirect"},  32'(pcRedirect),  32'(pr));
    check({tag, ".flushSource"}, 32'(flushSource), 32'(fs));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; sc = 0; fc = 0;
    rst = 1'b1;
    requireStall = 5'b00100; requireFlush = 5'b10000;
    timedStallValid = 1'b1; timedStallStage = 3'(EX); timedStallCycles = 4'd3;
    #1;
    check_ctrl("rst_forced", 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);
    step(); step();
    check("rst_stall_cnt", stallCycleCount, 32'd0);
    check("rst_flush_cnt", 32'(flushCount), 32'd0);
    rst = 1'b0;
    requireStall = '0; requireFlush = '0; timedStallValid = 1'b0;
    #1;
    check_ctrl("idle", 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);
    step();

    // Level stall at each stage: stall below K, bubble at boundary K.
    requireStall = 5'b00001; #1; check_ctrl("lvl0", 1'b1, 4'b0000, 4'b0001, 1'b0, 3'd0); step(); sc++;
    requireStall = 5'b00010; #1; check_ctrl("lvl1", 1'b1, 4'b0001, 4'b0010, 1'b0, 3'd0); step(); sc++;
    requireStall = 5'b00100; #1; check_ctrl("lvl2", 1'b1, 4'b0011, 4'b0100, 1'b0, 3'd0); step(); sc++;
    requireStall = 5'b01000; #1; check_ctrl("lvl3", 1'b1, 4'b0111, 4'b1000, 1'b0, 3'd0); step(); sc++;
    requireStall = 5'b10000; #1; check_ctrl("lvl4", 1'b1, 4'b1111, 4'b0000, 1'b0, 3'd0); step(); sc++;
    requireStall = '0; #1;
    check("lvl_count", stallCycleCount, 32'(sc));

    // Timed stall EX N=3: exactly three stalled cycles.
    timedStallValid = 1'b1; timedStallStage = 3'(EX); timedStallCycles = 4'd3; #1;
    check_ctrl("t3_c0", 1'b1, 4'b0011, 4'b0100, 1'b0, 3'd0);
    step(); sc++; timedStallValid = 1'b0; #1;
    check("t3_c1", 32'(pcStall), 32'd1);
    step(); sc++;
    check("t3_c2", 32'(pcStall), 32'd1);
    step(); sc++;
    check("t3_c3_done", 32'(pcStall), 32'd0);
    check("t3_count", stallCycleCount, 32'(sc));
    step();

    // Timed stall EX N=5, then an older MEM flush overrides and clears it.
    timedStallValid = 1'b1; timedStallStage = 3'(EX); timedStallCycles = 4'd5; #1;
    check("t5_c0", 32'(pcStall), 32'd1);
    step(); sc++; timedStallValid = 1'b0;
    requireFlush = 5'b01000; #1;
    check_ctrl("t5_flush", 1'b0, 4'b0000, 4'b0111, 1'b1, 3'd3);
    step(); fc++; requireFlush = '0; #1;
    check("t5_cleared", 32'(pcStall), 32'd0);
    check("t5_flush_cnt", 32'(flushCount), 32'(fc));
    step();

    // Older stall masks a younger flush; flush taken once the stall drops.
    requireStall = 5'b01000; requireFlush = 5'b00100; #1;
    check_ctrl("mask", 1'b1, 4'b0111, 4'b1000, 1'b0, 3'd0);
    step(); sc++; requireStall = '0; #1;
    check_ctrl("unmask", 1'b0, 4'b0000, 4'b0011, 1'b1, 3'd2);
    step(); fc++; requireFlush = 5'b10000; #1;
    check_ctrl("flush_wb", 1'b0, 4'b0000, 4'b1111, 1'b1, 3'd4);
    step(); fc++; requireFlush = '0; #1;

    // Reload shorter while longer remains: length unchanged (5 total).
    timedStallValid = 1'b1; timedStallStage = 3'(EX); timedStallCycles = 4'd5; #1;
    step(); sc++; timedStallCycles = 4'd2; #1;
    check("rl_short_c1", 32'(pcStall), 32'd1);
    step(); sc++; timedStallValid = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      #0; check($sformatf("rl_short_c%0d", c), 32'(pcStall), 32'd1);
      step(); sc++;
    end
    check("rl_short_done", 32'(pcStall), 32'd0);

    // Reload longer while cnt=1: stall lasts 8 cycles from reload.
    timedStallValid = 1'b1; timedStallCycles = 4'd2; #1;
    step(); sc++; timedStallCycles = 4'd8; #1;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("rl_long_c%0d", c), 32'(pcStall), 32'd1);
      step(); sc++; timedStallValid = 1'b0; #0;
    end
    check("rl_long_done", 32'(pcStall), 32'd0);
    check("rl_count", stallCycleCount, 32'(sc));

    // Ignored loads: zero length and out-of-range stage.
    timedStallValid = 1'b1; timedStallStage = 3'(EX); timedStallCycles = 4'd0; #1;
    check("zero_len", 32'(pcStall), 32'd0);
    timedStallStage = 3'd6; timedStallCycles = 4'd3; #1;
    check("bad_stage", 32'(pcStall), 32'd0);
    step(); timedStallValid = 1'b0; #1;
    check("bad_stage_after", 32'(pcStall), 32'd0);
    check("flush_count", 32'(flushCount), 32'(fc));

    // Reset during a timed stall plus a level stall at ID.
    timedStallValid = 1'b1; timedStallStage = 3'(MEM); timedStallCycles = 4'd6;
    requireStall = 5'b00010; #1;
    step(); timedStallValid = 1'b0; rst = 1'b1; #1;
    check_ctrl("rst_mid", 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);
    step();
    check("rst_mid_scnt", stallCycleCount, 32'd0);
    check("rst_mid_fcnt", 32'(flushCount), 32'd0);
    rst = 1'b0; sc = 0; #1;
    check_ctrl("post_rst", 1'b1, 4'b0001, 4'b0010, 1'b0, 3'd0);
    step(); sc++; requireStall = '0; #1;
    check("post_rst_idle", 32'(pcStall), 32'd0);
    check("post_rst_count", stallCycleCount, 32'(sc));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
